pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage pipelined ARM datapath (F/D/E/M/W).
- Generates the forwarding selects, stage stalls and stage flushes.
- Extends the basic load-use/branch hazard unit with a configurable multi-cycle data-memory wait FSM, a forwarding-disable mode (interlock-only), R15 exclusion and saturating performance counters.
- Instantiated once beside the datapath. Drives the stall/flush inputs of the IFetch, IDecode, Exec, memory and writeback pipeline registers.

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, forwarding, memory-wait and perf-count control for the 5-stage ARM pipeline
module pipe_hazard_ctrl #(
    parameter int REG_W   = 4,
    parameter int MEM_LAT = 1,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ra1d,
    input  logic [REG_W-1:0] ra2d,
    input  logic [REG_W-1:0] ra1e,
    input  logic [REG_W-1:0] ra2e,
    input  logic [REG_W-1:0] rd_e,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             reg_write_e,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             mem_to_reg_e,
    input  logic             mem_req_m,
    input  logic             pc_src_d,
    input  logic             pc_src_e,
    input  logic             pc_src_m,
    input  logic             pc_src_w,
    input  logic             branch_taken_e,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [REG_W-1:0] R15        = '1;
    localparam bit               HAS_WAIT   = (MEM_LAT > 1);
    localparam bit               FWD        = (FWD_EN != 0);
    localparam int               CNT_INIT_I = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
    localparam logic [3:0]       CNT_INIT   = CNT_INIT_I[3:0];
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       memwait;
    logic       ldrstall, rawstall, ls, pcwr_pend;

    // R15 is the PC, never a forwarding or interlock source
    function automatic logic hit(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst,
                                 input logic we);
        return we && (src == dst) && (src != R15);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (hit(src, rd_m, reg_write_m))
            return 2'b10;
        else if (hit(src, rd_w, reg_write_w))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        memwait   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_m && HAS_WAIT) begin
                    memwait   = 1'b1;
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    memwait = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ldrstall  = mem_to_reg_e && (hit(ra1d, rd_e, reg_write_e) || hit(ra2d, rd_e, reg_write_e));
        // W is not checked: the regfile writes on the falling edge
        rawstall  = hit(ra1d, rd_e, reg_write_e) || hit(ra2d, rd_e, reg_write_e) ||
                    hit(ra1d, rd_m, reg_write_m) || hit(ra2d, rd_m, reg_write_m);
        ls        = FWD ? ldrstall : rawstall;
        pcwr_pend = pc_src_d || pc_src_e || pc_src_m;
    end

    always_comb begin
        forward_ae = 2'b00;
        forward_be = 2'b00;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_w    = 1'b0;
        if (reset) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            if (FWD) begin
                forward_ae = fwd_sel(ra1e);
                forward_be = fwd_sel(ra2e);
            end
            if (memwait) begin
                // freeze the whole pipe; a taken branch waits in E until memory completes
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else begin
                stall_f = ls || pcwr_pend;
                stall_d = ls;
                flush_d = (pcwr_pend || pc_src_w || branch_taken_e) && !ls;
                flush_e = ls || branch_taken_e;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_f && (stall_cycles != CNT_MAX))
                stall_cycles <= stall_cycles + CNT_ONE;
            if (branch_taken_e && !memwait && (flush_count != CNT_MAX))
                flush_count <= flush_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed check of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ra1d, ra2d, ra1e, ra2e, rd_e, rd_m, rd_w;
    logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_req_m;
    logic       pc_src_d, pc_src_e, pc_src_m, pc_src_w, branch_taken_e;

    logic [1:0]  fae [3];
    logic [1:0]  fbe [3];
    logic        sf [3], sd [3], se [3], sm [3], fd [3], fe [3], fw [3];
    logic [31:0] sc_w [3];
    logic [31:0] fc_w [3];
    logic [3:0]  sc_c, fc_c;
    logic [10:0] hz [3];

    int     tests = 0;
    int     fails = 0;
    int     lat [3]  = '{1, 4, 8};
    bit     fwd [3]  = '{1'b1, 1'b1, 1'b0};
    longint cmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    int     rem [3];
    longint sc [3];
    longint fc [3];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(4), .MEM_LAT(1), .FWD_EN(1), .CNT_W(32)) u_dut_a (
        .clk(clk), .reset(reset), .ra1d(ra1d), .ra2d(ra2d), .ra1e(ra1e), .ra2e(ra2e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .reg_write_e(reg_write_e),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .mem_to_reg_e(mem_to_reg_e),
        .mem_req_m(mem_req_m), .pc_src_d(pc_src_d), .pc_src_e(pc_src_e), .pc_src_m(pc_src_m),
        .pc_src_w(pc_src_w), .branch_taken_e(branch_taken_e),
        .forward_ae(fae[0]), .forward_be(fbe[0]), .stall_f(sf[0]), .stall_d(sd[0]),
        .stall_e(se[0]), .stall_m(sm[0]), .flush_d(fd[0]), .flush_e(fe[0]), .flush_w(fw[0]),
        .stall_cycles(sc_w[0]), .flush_count(fc_w[0]));

    pipe_hazard_ctrl #(.REG_W(4), .MEM_LAT(4), .FWD_EN(1), .CNT_W(32)) u_dut_b (
        .clk(clk), .reset(reset), .ra1d(ra1d), .ra2d(ra2d), .ra1e(ra1e), .ra2e(ra2e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .reg_write_e(reg_write_e),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .mem_to_reg_e(mem_to_reg_e),
        .mem_req_m(mem_req_m), .pc_src_d(pc_src_d), .pc_src_e(pc_src_e), .pc_src_m(pc_src_m),
        .pc_src_w(pc_src_w), .branch_taken_e(branch_taken_e),
        .forward_ae(fae[1]), .forward_be(fbe[1]), .stall_f(sf[1]), .stall_d(sd[1]),
        .stall_e(se[1]), .stall_m(sm[1]), .flush_d(fd[1]), .flush_e(fe[1]), .flush_w(fw[1]),
        .stall_cycles(sc_w[1]), .flush_count(fc_w[1]));

    pipe_hazard_ctrl #(.REG_W(4), .MEM_LAT(8), .FWD_EN(0), .CNT_W(4)) u_dut_c (
        .clk(clk), .reset(reset), .ra1d(ra1d), .ra2d(ra2d), .ra1e(ra1e), .ra2e(ra2e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .reg_write_e(reg_write_e),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .mem_to_reg_e(mem_to_reg_e),
        .mem_req_m(mem_req_m), .pc_src_d(pc_src_d), .pc_src_e(pc_src_e), .pc_src_m(pc_src_m),
        .pc_src_w(pc_src_w), .branch_taken_e(branch_taken_e),
        .forward_ae(fae[2]), .forward_be(fbe[2]), .stall_f(sf[2]), .stall_d(sd[2]),
        .stall_e(se[2]), .stall_m(sm[2]), .flush_d(fd[2]), .flush_e(fe[2]), .flush_w(fw[2]),
        .stall_cycles(sc_c), .flush_count(fc_c));

    assign sc_w[2] = {28'd0, sc_c};
    assign fc_w[2] = {28'd0, fc_c};

    // {forward_ae, forward_be, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
    for (genvar g = 0; g < 3; g++) begin : g_pack
        assign hz[g] = {fae[g], fbe[g], sf[g], sd[g], se[g], sm[g], fd[g], fe[g], fw[g]};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m(input logic [3:0] s, input logic [3:0] d, input logic we);
        return we && (s == d) && (s != 4'hF);
    endfunction

    function automatic logic [1:0] fsel(input logic [3:0] s);
        if (m(s, rd_m, reg_write_m)) return 2'b10;
        if (m(s, rd_w, reg_write_w)) return 2'b01;
        return 2'b00;
    endfunction

    // rem = cycles of the current memory op still to run (MEM_LAT-1 stalled + 1 release)
    function automatic logic [10:0] exp_hz(input int l, input bit fw_en, input int r, output bit mw);
        bit ls, pcw, raw_e, raw_m;
        logic [1:0] a, b;
        mw    = (r > 0) ? (r > 1) : (mem_req_m && l > 1);
        raw_e = m(ra1d, rd_e, reg_write_e) || m(ra2d, rd_e, reg_write_e);
        raw_m = m(ra1d, rd_m, reg_write_m) || m(ra2d, rd_m, reg_write_m);
        ls    = fw_en ? (mem_to_reg_e && raw_e) : (raw_e || raw_m);
        pcw   = pc_src_d || pc_src_e || pc_src_m;
        a     = fw_en ? fsel(ra1e) : 2'b00;
        b     = fw_en ? fsel(ra2e) : 2'b00;
        if (reset)
            return 11'b000_0000_0110;
        if (mw)
            return {a, b, 7'b1111001};
        return {a, b, ls | pcw, ls, 2'b00, (pcw | pc_src_w | branch_taken_e) & ~ls,
                ls | branch_taken_e, 1'b0};
    endfunction

    task automatic cycle();
        logic [10:0] e;
        bit mw;
        @(negedge clk);
        if (reset)
            for (int i = 0; i < 3; i++) begin
                rem[i] = 0; sc[i] = 0; fc[i] = 0;
            end
        for (int i = 0; i < 3; i++) begin
            e = exp_hz(lat[i], fwd[i], rem[i], mw);
            check($sformatf("hz%0d", i), {53'd0, hz[i]}, {53'd0, e});
            check($sformatf("stall_cycles%0d", i), {32'd0, sc_w[i]}, sc[i]);
            check($sformatf("flush_count%0d", i), {32'd0, fc_w[i]}, fc[i]);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            e = exp_hz(lat[i], fwd[i], rem[i], mw);
            if (!reset) begin
                if (e[6] && sc[i] != cmax[i]) sc[i]++;
                if (branch_taken_e && !mw && fc[i] != cmax[i]) fc[i]++;
                if (rem[i] > 0) rem[i]--;
                else if (mem_req_m && lat[i] > 1) rem[i] = lat[i] - 1;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        {ra1d, ra2d, ra1e, ra2e, rd_e, rd_m, rd_w} = '0;
        {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_req_m} = '0;
        {pc_src_d, pc_src_e, pc_src_m, pc_src_w, branch_taken_e} = '0;
    endtask

    function automatic logic [3:0] rreg();
        int r = $urandom_range(0, 4);
        return (r == 4) ? 4'hF : 4'(r);
    endfunction

    initial begin
        clear_inputs();
        reset = 1'b1;
        #3;
        check("reset_hz", {53'd0, hz[0]}, 64'h6);
        check("reset_cnt", {32'd0, sc_w[1]}, 64'd0);
        cycle(); cycle();
        reset = 1'b0;

        // memory wait with a branch arriving during it
        mem_req_m = 1'b1;
        cycle();
        mem_req_m = 1'b0;
        branch_taken_e = 1'b1;
        repeat (3) cycle();
        branch_taken_e = 1'b0;
        repeat (2) cycle();
        check("memwait_stalls_b", {32'd0, sc_w[1]}, 64'd3);
        check("held_branch_b", {32'd0, fc_w[1]}, 64'd1);
        check("branches_a", {32'd0, fc_w[0]}, 64'd3);
        check("held_branch_c", {32'd0, fc_w[2]}, 64'd0);
        repeat (4) cycle();

        rd_m = 4'd3; reg_write_m = 1'b1; rd_w = 4'd3; reg_write_w = 1'b1; ra1e = 4'd3;
        #2 check("fwd_m", {62'd0, fae[0]}, 64'd2);
        cycle();
        reg_write_m = 1'b0;
        #2 check("fwd_w", {62'd0, fae[0]}, 64'd1);
        cycle();
        reg_write_m = 1'b1; ra1e = 4'hF; rd_m = 4'hF; rd_w = 4'hF;
        #2 check("fwd_r15", {62'd0, fae[0]}, 64'd0);
        cycle();

        clear_inputs();
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; rd_e = 4'd5; ra2d = 4'd5;
        #2 check("load_use", {53'd0, hz[0]}, 64'h62);
        cycle();

        clear_inputs();
        rd_m = 4'd2; reg_write_m = 1'b1; ra1d = 4'd2;
        #2 check("interlock_c", {53'd0, hz[2]}, 64'h62);
        cycle();

        clear_inputs();
        branch_taken_e = 1'b1;
        #2 check("branch", {53'd0, hz[0]}, 64'h6);
        cycle();
        branch_taken_e = 1'b0; pc_src_d = 1'b1;
        #2 check("pc_src_d", {53'd0, hz[0]}, 64'h44);
        cycle();

        clear_inputs();
        mem_req_m = 1'b1;
        cycle();
        mem_req_m = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        #2 check("reset_mid_hz", {53'd0, hz[2]}, 64'h6);
        check("reset_mid_sc", {32'd0, sc_w[2]}, 64'd0);
        check("reset_mid_fc", {32'd0, fc_w[2]}, 64'd0);
        cycle(); cycle();
        reset = 1'b0;
        #2 check("idle_after_reset", {53'd0, hz[2]}, 64'h0);
        cycle();

        for (int n = 0; n < 600; n++) begin
            ra1d = rreg(); ra2d = rreg(); ra1e = rreg(); ra2e = rreg();
            rd_e = rreg(); rd_m = rreg(); rd_w = rreg();
            reg_write_e    = 1'($urandom_range(0, 1));
            reg_write_m    = 1'($urandom_range(0, 1));
            reg_write_w    = 1'($urandom_range(0, 1));
            mem_to_reg_e   = ($urandom_range(0, 3) == 0);
            mem_req_m      = ($urandom_range(0, 5) == 0);
            pc_src_d       = ($urandom_range(0, 9) == 0);
            pc_src_e       = ($urandom_range(0, 9) == 0);
            pc_src_m       = ($urandom_range(0, 9) == 0);
            pc_src_w       = ($urandom_range(0, 9) == 0);
            branch_taken_e = ($urandom_range(0, 6) == 0);
            reset          = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
